// File: rtl/pulse_arb.sv
// rtl/pulse_arb.sv - round-robin arbiter sharing one registered pulse channel among NREQ edge requesters
// Optional PULSE_ARB_CNT_EN: 2-bit saturating pending counter per requester instead of a single flag.
module pulse_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 1,
  parameter int GAP   = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NREQ-1:0] sig,
  input  logic            clr_drop,
  output logic            pulse_sig,
  output logic [IW-1:0]   pulse_id,
  output logic [NREQ-1:0] pend,
  output logic [NREQ-1:0] drop
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam int CMAX = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] W_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] G_LAST = CW'((GAP > 0) ? GAP - 1 : 0);

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_pulse;
  logic [IW-1:0]   r_id;
  logic [IW-1:0]   r_last;
  logic [NREQ-1:0] r_sig_q;
  logic [NREQ-1:0] r_drop;

  logic [NREQ-1:0] w_rise;
  logic [NREQ-1:0] w_req;
  logic [NREQ-1:0] w_gnt_vec;
  logic [NREQ-1:0] w_drop_set;
  logic [IW-1:0]   w_gnt_idx;
  logic            w_gnt_ok;
  logic            w_fire;
  int              w_scan;

  assign w_rise = sig & ~r_sig_q;

  // First pending requester after the previous winner, wrapping at NREQ-1.
  always_comb begin
    w_gnt_ok  = 1'b0;
    w_gnt_idx = '0;
    w_scan    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_scan = (int'(r_last) + k) % NREQ;
      if (!w_gnt_ok && w_req[w_scan]) begin
        w_gnt_ok  = 1'b1;
        w_gnt_idx = IW'(w_scan);
      end
    end
  end

  assign w_fire    = (r_state == S_IDLE) && w_gnt_ok;
  assign w_gnt_vec = w_fire ? ({{(NREQ-1){1'b0}}, 1'b1} << w_gnt_idx) : '0;

`ifdef PULSE_ARB_CNT_EN
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    logic [1:0] r_pcnt;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_pcnt <= 2'd0;
      end else if (w_rise[gi] && !w_gnt_vec[gi]) begin
        if (r_pcnt != 2'd3) r_pcnt <= r_pcnt + 2'd1;
      end else if (!w_rise[gi] && w_gnt_vec[gi]) begin
        r_pcnt <= r_pcnt - 2'd1;
      end
    end

    assign w_req[gi]      = (r_pcnt != 2'd0);
    assign w_drop_set[gi] = w_rise[gi] && !w_gnt_vec[gi] && (r_pcnt == 2'd3);
  end
`else
  logic [NREQ-1:0] r_pend;

  // A rise on the requester being granted keeps it pending.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_pend <= '0;
    else       r_pend <= w_rise | (r_pend & ~w_gnt_vec);
  end

  assign w_req      = r_pend;
  assign w_drop_set = w_rise & r_pend & ~w_gnt_vec;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sig_q <= '1;
      r_drop  <= '0;
    end else begin
      r_sig_q <= sig;
      r_drop  <= w_drop_set | (r_drop & ~{NREQ{clr_drop}});
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_id    <= '0;
      r_last  <= IW'(NREQ - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            r_state <= S_PULSE;
            r_cnt   <= W_LAST;
            r_pulse <= 1'b1;
            r_id    <= w_gnt_idx;
            r_last  <= w_gnt_idx;
          end
        end
        S_PULSE: begin
          if (r_cnt == '0) begin
            r_pulse <= 1'b0;
            if (GAP > 0) begin
              r_state <= S_GAP;
              r_cnt   <= G_LAST;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_GAP: begin
          if (r_cnt == '0) r_state <= S_IDLE;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        default: begin
          r_state <= S_IDLE;
          r_pulse <= 1'b0;
        end
      endcase
    end
  end

  assign pulse_sig = r_pulse;
  assign pulse_id  = r_id;
  assign pend      = w_req;
  assign drop      = r_drop;

endmodule

// File: tb/tb_pulse_arb.sv
// tb/tb_pulse_arb.sv - scoreboard bench for pulse_arb against a time-budget reference model
module tb_pulse_arb;
  localparam int NREQ  = 4;
  localparam int WIDTH = 1;
  localparam int GAP   = 2;
  localparam int IW    = 2;
`ifdef PULSE_ARB_CNT_EN
  localparam int ID1_PULSES = 3;
  localparam int DROP_EXP   = 0;
`else
  localparam int ID1_PULSES = 1;
  localparam int DROP_EXP   = 1;
`endif

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [NREQ-1:0] sig = 4'b0101;
  logic            clr_drop = 1'b0;
  logic            pulse_sig;
  logic [IW-1:0]   pulse_id;
  logic [NREQ-1:0] pend;
  logic [NREQ-1:0] drop;

  pulse_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .GAP(GAP)) dut (
    .clk(clk), .rstn(rstn), .sig(sig), .clr_drop(clr_drop),
    .pulse_sig(pulse_sig), .pulse_id(pulse_id), .pend(pend), .drop(drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending counts, sticky drops, and the edge at which the channel is next free.
  int m_cnt [NREQ];
  bit m_drop [NREQ];
  bit [NREQ-1:0] m_sigq;
  int m_last, m_edge, m_free, m_pstart, m_id;
  int exp_q[$];
  int obs_ids[$];
  int obs_edges[$];
  bit mon_en = 1'b0;
  logic prev_ps = 1'b0;

  function automatic void model_reset();
    for (int i = 0; i < NREQ; i++) begin
      m_cnt[i]  = 0;
      m_drop[i] = 1'b0;
    end
    m_sigq   = '1;
    m_last   = NREQ - 1;
    m_free   = 0;
    m_pstart = -1000;
    m_id     = 0;
    exp_q.delete();
  endfunction

  function automatic void model_step();
    int g;
    bit rise, gi, dset;
    g = -1;
    m_edge++;
    if (m_edge >= m_free) begin
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (m_last + k) % NREQ;
        if (g < 0 && m_cnt[idx] > 0) g = idx;
      end
    end
    if (g >= 0) begin
      m_last   = g;
      m_id     = g;
      m_pstart = m_edge;
      m_free   = m_edge + WIDTH + GAP + 1;
      exp_q.push_back(g);
    end
    for (int i = 0; i < NREQ; i++) begin
      rise = sig[i] && !m_sigq[i];
      gi   = (i == g);
      dset = 1'b0;
`ifdef PULSE_ARB_CNT_EN
      if (rise && !gi) begin
        if (m_cnt[i] == 3) dset = 1'b1;
        else m_cnt[i]++;
      end else if (gi && !rise) begin
        m_cnt[i]--;
      end
`else
      if (rise) begin
        if (m_cnt[i] != 0 && !gi) dset = 1'b1;
        m_cnt[i] = 1;
      end else if (gi) begin
        m_cnt[i] = 0;
      end
`endif
      m_drop[i] = dset ? 1'b1 : (clr_drop ? 1'b0 : m_drop[i]);
    end
    m_sigq = sig;
  endfunction

  function automatic logic [NREQ-1:0] m_pend_vec();
    logic [NREQ-1:0] v;
    for (int i = 0; i < NREQ; i++) v[i] = (m_cnt[i] != 0);
    return v;
  endfunction

  function automatic logic [NREQ-1:0] m_drop_vec();
    logic [NREQ-1:0] v;
    for (int i = 0; i < NREQ; i++) v[i] = m_drop[i];
    return v;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("pulse_sig", pulse_sig, (m_edge >= m_pstart) && (m_edge < m_pstart + WIDTH));
      chk("pulse_id", pulse_id, m_id);
      chk("pend", pend, m_pend_vec());
      chk("drop", drop, m_drop_vec());
      if (pulse_sig === 1'b1 && prev_ps !== 1'b1) begin
        obs_ids.push_back(int'(pulse_id));
        obs_edges.push_back(m_edge);
        if (exp_q.size() == 0) chk("sb_unexpected_pulse", exp_q.size(), 1);
        else                   chk("sb_pulse_id", pulse_id, exp_q.pop_front());
      end
      prev_ps = pulse_sig;
    end
  end

  task automatic cyc(input logic [NREQ-1:0] s, input logic c);
    sig = s;
    clr_drop = c;
    @(posedge clk);
    if (rstn) model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rstn = 1'b0;
    model_reset();
    #1 chk("rst_async_pulse", pulse_sig, 0);
    @(posedge clk);
    @(negedge clk);
    #2 rstn = 1'b1;
  endtask

  initial begin
    logic [NREQ-1:0] s;
    int n1;
    m_edge = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("rst_pulse_sig", pulse_sig, 0);
    chk("rst_pulse_id", pulse_id, 0);
    chk("rst_pend", pend, 0);
    chk("rst_drop", drop, 0);
    mon_en = 1'b1;
    #2 rstn = 1'b1;

    // sig held high through reset release raises nothing
    for (int i = 0; i < 10; i++) begin
      cyc(4'b0101, 1'b0);
      chk("hold_pend", pend, 0);
      chk("hold_pulse", pulse_sig, 0);
    end

    // single request latency and width
    for (int i = 0; i < 3; i++) cyc(4'b0000, 1'b0);
    cyc(4'b0100, 1'b0);
    chk("lat_pend", pend, 4'b0100);
    chk("lat_pulse_pre", pulse_sig, 0);
    cyc(4'b0100, 1'b0);
    chk("lat_pulse_on", pulse_sig, 1);
    chk("lat_pulse_id", pulse_id, 2);
    cyc(4'b0100, 1'b0);
    chk("lat_pulse_off", pulse_sig, 0);
    chk("lat_id_hold", pulse_id, 2);

    // all four at once: round robin order and spacing
    do_reset();
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    obs_ids.delete();
    obs_edges.delete();
    for (int i = 0; i < 20; i++) cyc(4'b1111, 1'b0);
    chk("rr_count", obs_ids.size(), 4);
    for (int i = 0; i < 4; i++) chk("rr_order", obs_ids[i], i);
    for (int i = 1; i < 4; i++) chk("rr_spacing", obs_edges[i] - obs_edges[i-1], WIDTH + GAP + 1);

    // three rises on requester 1 while the channel is busy
    for (int i = 0; i < 3; i++) cyc(4'b0000, 1'b0);
    obs_ids.delete();
    cyc(4'b0011, 1'b0);
    cyc(4'b0001, 1'b0);
    cyc(4'b0011, 1'b0);
    cyc(4'b0001, 1'b0);
    cyc(4'b0011, 1'b0);
    for (int i = 0; i < 30; i++) cyc(4'b0001, 1'b0);
    n1 = 0;
    foreach (obs_ids[i]) if (obs_ids[i] == 1) n1++;
    chk("burst_id1_pulses", n1, ID1_PULSES);
    chk("burst_drop1", drop[1], DROP_EXP);

    // clr_drop coinciding with a new drop event
    do_reset();
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    cyc(4'b0011, 1'b0);
    cyc(4'b1011, 1'b0);
    cyc(4'b0011, 1'b0);
    cyc(4'b1011, 1'b0);
    cyc(4'b0011, 1'b0);
    chk("clr_drop3_set", drop[3], DROP_EXP);
    cyc(4'b1011, 1'b1);
    chk("clr_drop3_hold", drop[3], DROP_EXP);
    cyc(4'b0011, 1'b1);
    chk("clr_drop3_clear", drop[3], 0);

    // reset in the first pulse cycle discards everything
    for (int i = 0; i < 20; i++) cyc(4'b0000, 1'b0);
    cyc(4'b0001, 1'b0);
    cyc(4'b0001, 1'b0);
    chk("midrst_pulse_on", pulse_sig, 1);
    do_reset();
    obs_ids.delete();
    for (int i = 0; i < 10; i++) cyc(4'b0001, 1'b0);
    chk("midrst_no_pulse", obs_ids.size(), 0);
    cyc(4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) cyc(4'b0001, 1'b0);
    chk("midrst_fresh_pulse", obs_ids.size(), 1);

    // randomized traffic
    s = sig;
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < NREQ; b++) if ($urandom_range(0, 2) == 0) s[b] = ~s[b];
      cyc(s, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 299) == 0) do_reset();
    end
    for (int i = 0; i < 80; i++) cyc(s, 1'b0);
    chk("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
